// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage ALU: function codes, FSM states
// and the operation selector for the iterative multiply/divide unit.
package alu_pkg;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_XOR  = 4'b0011;
    localparam logic [3:0] ALU_SLL  = 4'b0100;
    localparam logic [3:0] ALU_SLTU = 4'b0101;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SUBU = 4'b0111;
    localparam logic [3:0] ALU_SRL  = 4'b1000;
    localparam logic [3:0] ALU_MUL  = 4'b1001;
    localparam logic [3:0] ALU_SLT  = 4'b1010;
    localparam logic [3:0] ALU_DIV  = 4'b1011;
    localparam logic [3:0] ALU_SRA  = 4'b1100;
    localparam logic [3:0] ALU_REM  = 4'b1101;

    typedef enum logic [1:0] {ST_IDLE, ST_ITER, ST_DONE} state_t;
    typedef enum logic [1:0] {MD_MUL, MD_DIV, MD_REM} md_op_t;

    function automatic logic is_iter_fn(input logic [3:0] fn);
        return (fn == ALU_MUL) || (fn == ALU_DIV) || (fn == ALU_REM);
    endfunction

    function automatic md_op_t md_op_of(input logic [3:0] fn);
        if (fn == ALU_DIV)
            return MD_DIV;
        else if (fn == ALU_REM)
            return MD_REM;
        else
            return MD_MUL;
    endfunction

endpackage

// File: rtl/alu_exec_unit_if.sv
// Operation-in / result-out handshake bundle of the execute-stage ALU.
interface alu_exec_unit_if #(parameter int WIDTH = 32);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       alu_fn;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             con_beq;
    logic             con_bnq;
    logic             con_blt;
    logic             con_bgt;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             branch_taken;
    logic             busy;

    modport master (
        output in_valid, alu_fn, src_a, src_b, con_beq, con_bnq, con_blt, con_bgt, out_ready,
        input  in_ready, out_valid, result, zero, branch_taken, busy
    );

    modport slave (
        input  in_valid, alu_fn, src_a, src_b, con_beq, con_bnq, con_blt, con_bgt, out_ready,
        output in_ready, out_valid, result, zero, branch_taken, busy
    );
endinterface

// File: rtl/alu_muldiv_iter.sv
// One-bit-per-cycle shift-add multiplier and restoring divider. done is
// asserted during the last step, with result already holding the final value.
module alu_muldiv_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  md_op_t           op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] result
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic             running_reg;
    logic [CW-1:0]    count_reg;
    md_op_t           op_reg;
    logic [WIDTH-1:0] a_reg;
    logic             div0_reg, neg_q_reg, neg_r_reg;
    // x: product accumulator / partial remainder; y: multiplicand / quotient; z: multiplier / divisor
    logic [WIDTH-1:0] x_reg, y_reg, z_reg;
    logic [WIDTH-1:0] x_next, y_next, z_next;
    logic [WIDTH:0]   trial, diff;
    logic [WIDTH-1:0] a_mag, b_mag;

    assign a_mag = a[WIDTH-1] ? -a : a;
    assign b_mag = b[WIDTH-1] ? -b : b;
    assign done  = running_reg && (count_reg == LAST);

    always_comb begin
        trial  = {x_reg, y_reg[WIDTH-1]};
        diff   = trial - {1'b0, z_reg};
        x_next = x_reg;
        y_next = y_reg;
        z_next = z_reg;
        if (op_reg == MD_MUL) begin
            x_next = z_reg[0] ? (x_reg + y_reg) : x_reg;
            y_next = y_reg << 1;
            z_next = z_reg >> 1;
        end else begin
            x_next = diff[WIDTH] ? trial[WIDTH-1:0] : diff[WIDTH-1:0];
            y_next = {y_reg[WIDTH-2:0], ~diff[WIDTH]};
        end
    end

    // MIN / -1 needs no special case: the magnitude quotient 2^(WIDTH-1) negates to MIN.
    always_comb begin
        result = '0;
        case (op_reg)
            MD_MUL: result = x_next;
            MD_DIV: result = div0_reg ? '1 : (neg_q_reg ? -y_next : y_next);
            MD_REM: result = div0_reg ? a_reg : (neg_r_reg ? -x_next : x_next);
            default: result = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            running_reg <= 1'b0;
            count_reg   <= '0;
            op_reg      <= MD_MUL;
            a_reg       <= '0;
            div0_reg    <= 1'b0;
            neg_q_reg   <= 1'b0;
            neg_r_reg   <= 1'b0;
            x_reg       <= '0;
            y_reg       <= '0;
            z_reg       <= '0;
        end else if (start) begin
            running_reg <= 1'b1;
            count_reg   <= '0;
            op_reg      <= op;
            a_reg       <= a;
            div0_reg    <= (b == '0);
            neg_q_reg   <= a[WIDTH-1] ^ b[WIDTH-1];
            neg_r_reg   <= a[WIDTH-1];
            x_reg       <= '0;
            y_reg       <= (op == MD_MUL) ? a : a_mag;
            z_reg       <= (op == MD_MUL) ? b : b_mag;
        end else if (running_reg) begin
            x_reg     <= x_next;
            y_reg     <= y_next;
            z_reg     <= z_next;
            count_reg <= count_reg + 1'b1;
            if (done)
                running_reg <= 1'b0;
        end
    end
endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle datapath and branch resolution, with
// MUL/DIV/REM handed to the iterative unit while the handshake stalls.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic            clk,
    input  logic            reset,
    alu_exec_unit_if.slave  io
);
    localparam int SHW = $clog2(WIDTH);

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] result_reg;
    logic             zero_reg, branch_reg;
    logic             accept, start_iter;
    logic [WIDTH-1:0] alu_comb;
    logic             branch_comb, a_eq_b, a_lt_b;
    logic [SHW-1:0]   shamt;
    logic             md_done;
    logic [WIDTH-1:0] md_result;

    assign io.in_ready     = (state_reg == ST_IDLE) || ((state_reg == ST_DONE) && io.out_ready);
    assign io.out_valid    = (state_reg == ST_DONE);
    assign io.busy         = (state_reg == ST_ITER);
    assign io.result       = result_reg;
    assign io.zero         = zero_reg;
    assign io.branch_taken = branch_reg;

    assign accept     = io.in_valid && io.in_ready;
    assign start_iter = accept && is_iter_fn(io.alu_fn);
    assign shamt      = io.src_b[SHW-1:0];

    always_comb begin
        alu_comb = '0;
        case (io.alu_fn)
            ALU_AND:  alu_comb = io.src_a & io.src_b;
            ALU_OR:   alu_comb = io.src_a | io.src_b;
            ALU_ADD:  alu_comb = io.src_a + io.src_b;
            ALU_XOR:  alu_comb = io.src_a ^ io.src_b;
            ALU_SLL:  alu_comb = io.src_a << shamt;
            ALU_SLTU: alu_comb = {{(WIDTH-1){1'b0}}, (io.src_a < io.src_b)};
            ALU_SUB:  alu_comb = io.src_a - io.src_b;
            ALU_SUBU: alu_comb = io.src_a - io.src_b;
            ALU_SRL:  alu_comb = io.src_a >> shamt;
            ALU_SLT:  alu_comb = {{(WIDTH-1){1'b0}}, ($signed(io.src_a) < $signed(io.src_b))};
            ALU_SRA:  alu_comb = $unsigned($signed(io.src_a) >>> shamt);
            default:  alu_comb = '0;
        endcase
    end

    // Only the unsigned-compare subtract resolves branches as unsigned.
    always_comb begin
        a_eq_b      = (io.src_a == io.src_b);
        a_lt_b      = (io.alu_fn == ALU_SUBU) ? (io.src_a < io.src_b)
                                              : ($signed(io.src_a) < $signed(io.src_b));
        branch_comb = (io.con_beq & a_eq_b) | (io.con_bnq & ~a_eq_b) |
                      (io.con_blt & a_lt_b) | (io.con_bgt & ~a_lt_b);
    end

    alu_muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
        .clk    (clk),
        .reset  (reset),
        .start  (start_iter),
        .op     (md_op_of(io.alu_fn)),
        .a      (io.src_a),
        .b      (io.src_b),
        .done   (md_done),
        .result (md_result)
    );

    always_ff @(posedge clk) begin
        if (reset)
            state_reg <= ST_IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE, ST_DONE: begin
                if (accept)
                    state_next = is_iter_fn(io.alu_fn) ? ST_ITER : ST_DONE;
                else if ((state_reg == ST_DONE) && io.out_ready)
                    state_next = ST_IDLE;
            end
            ST_ITER: if (md_done) state_next = ST_DONE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            result_reg <= '0;
            zero_reg   <= 1'b0;
            branch_reg <= 1'b0;
        end else if (accept) begin
            branch_reg <= branch_comb;
            if (!start_iter) begin
                result_reg <= alu_comb;
                zero_reg   <= (alu_comb == '0);
            end
        end else if ((state_reg == ST_ITER) && md_done) begin
            result_reg <= md_result;
            zero_reg   <= (md_result == '0);
        end
    end
endmodule
